fpu_mul_acc: RTL and testbench

- Iterative fixed-point multiply / multiply-accumulate execution stage. Sits directly downstream of the FPU input mux.
- Consumes two or three 64-bit signed fixed-point operands selected by that mux, which supplies general-register data, the constant one, XMM data or negated XMM data.
- Produces a saturated 64-bit result for XMM register writeback.
- Multi-cycle shift-add datapath with valid/ready handshakes on both sides; one operation in flight.

---
 rtl/fpu_mul_acc_pkg.sv | 25 ++
 rtl/fpu_mul_acc_if.sv | 27 ++
 rtl/fpu_sat_add64.sv | 24 ++
 rtl/fpu_mul_acc.sv | 154 +++++++++++++++
 tb/tb_fpu_mul_acc.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_mul_acc_pkg.sv
// fpu_mul_acc_pkg
// Shared definitions for the fixed-point multiply / multiply-accumulate stage:
//   - state_t   : controller state encoding
//   - ONE       : Q-format constant 1.0, shared with the FPU input mux
//   - SAT_MAX/MIN: saturation bounds of the 64-bit signed result
//   - mag64()   : two's-complement magnitude (|-2^63| yields 2^63 unsigned)
package fpu_mul_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int          FRAC_BITS_DEF = 32;
  localparam logic [63:0] ONE           = 64'(1) << FRAC_BITS_DEF;
  localparam logic [63:0] SAT_MAX       = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MIN       = 64'h8000_0000_0000_0000;

  function automatic logic [63:0] mag64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/fpu_mul_acc_if.sv
// fpu_mul_acc_if
// Operand/result handshake bundle of the multiply-accumulate stage.
//   in_*  : operand set from the input mux (valid/ready)
//   out_* : saturated result towards XMM writeback (valid/ready)
// master = producer of operands / consumer of results, slave = the stage.
interface fpu_mul_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mac;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [63:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_ovf;

  modport master (
    output in_valid, in_mac, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_mac, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fpu_sat_add64.sv
// fpu_sat_add64
// Combinational 64-bit signed add with saturation.
//   a, b : signed 64-bit operands
//   sum  : a+b clamped to [SAT_MIN, SAT_MAX]
//   ovf  : 1 when clamping occurred
module fpu_sat_add64
  import fpu_mul_acc_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum,
  output logic        ovf
);

  logic [64:0] wide;

  always_comb begin
    wide = {a[63], a} + {b[63], b};
    // Overflow when the 65-bit sign differs from bit 63; bit 64 is the true sign.
    ovf  = wide[64] ^ wide[63];
    sum  = ovf ? (wide[64] ? SAT_MIN : SAT_MAX) : wide[63:0];
  end

endmodule

// File: rtl/fpu_mul_acc.sv
// fpu_mul_acc
// Iterative shift-add fixed-point multiply / multiply-accumulate with
// saturated 64-bit result. One operation in flight.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, aborts any operation
//   bus   : fpu_mul_acc_if.slave (operand and result handshakes)
// Result is out_valid ITER+1 clocks after the accepting edge.
module fpu_mul_acc
  import fpu_mul_acc_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int STEP_BITS = 2
) (
  input  logic         clk,
  input  logic         reset,
  fpu_mul_acc_if.slave bus
);

  localparam int ITER  = 64 / STEP_BITS;
  localparam int CNT_W = $clog2(ITER + 1);

  state_t             state_reg, state_next;
  logic [127:0]       acc_reg;
  logic [127:0]       a_sh_reg;     // |a| pre-shifted to the current step's weight
  logic [63:0]        b_mag_reg;
  logic [63:0]        c_reg;
  logic               sign_reg;
  logic               mac_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [63:0]        out_data_reg;
  logic               out_ovf_reg;

  // Partial products for the STEP_BITS multiplier bits retired this cycle.
  logic [127:0] pp [STEP_BITS];
  logic [127:0] step_sum;

  generate
    for (genvar gi = 0; gi < STEP_BITS; gi++) begin : g_pp
      assign pp[gi] = b_mag_reg[gi] ? (a_sh_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      step_sum = step_sum + pp[i];
    end
  end

  // Scale, saturate on magnitude, then apply the sign.
  logic [127:0] p;
  logic [63:0]  mul_res;
  logic         mul_ovf;
  logic [63:0]  add_sum;
  logic         add_ovf;
  logic [63:0]  fin_data;
  logic         fin_ovf;

  always_comb begin
    p       = acc_reg >> FRAC_BITS;
    mul_res = '0;
    mul_ovf = 1'b0;
    if (!sign_reg) begin
      if (p > 128'(SAT_MAX)) begin
        mul_res = SAT_MAX;
        mul_ovf = 1'b1;
      end else begin
        mul_res = p[63:0];
      end
    end else begin
      // A magnitude of exactly 2^63 is representable as SAT_MIN.
      if (p > 128'(SAT_MIN)) begin
        mul_res = SAT_MIN;
        mul_ovf = 1'b1;
      end else begin
        mul_res = ~p[63:0] + 64'd1;
      end
    end
  end

  fpu_sat_add64 u_sat_add (
    .a   (mul_res),
    .b   (c_reg),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign fin_data = mac_reg ? add_sum : mul_res;
  assign fin_ovf  = mul_ovf | (mac_reg & add_ovf);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.in_valid) state_next = ST_BUSY;
      ST_BUSY:   if (cnt_reg == CNT_W'(1)) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg      <= '0;
      a_sh_reg     <= '0;
      b_mag_reg    <= '0;
      c_reg        <= '0;
      sign_reg     <= 1'b0;
      mac_reg      <= 1'b0;
      cnt_reg      <= '0;
      out_data_reg <= '0;
      out_ovf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sh_reg  <= {64'd0, mag64(bus.in_a)};
            b_mag_reg <= mag64(bus.in_b);
            sign_reg  <= bus.in_a[63] ^ bus.in_b[63];
            c_reg     <= bus.in_c;
            mac_reg   <= bus.in_mac;
            acc_reg   <= '0;
            cnt_reg   <= CNT_W'(ITER);
          end
        end
        ST_BUSY: begin
          acc_reg   <= acc_reg + step_sum;
          a_sh_reg  <= a_sh_reg << STEP_BITS;
          b_mag_reg <= b_mag_reg >> STEP_BITS;
          cnt_reg   <= cnt_reg - CNT_W'(1);
        end
        ST_FINISH: begin
          out_data_reg <= fin_data;
          out_ovf_reg  <= fin_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.out_data  = out_data_reg;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_fpu_mul_acc.sv
// tb_fpu_mul_acc
// Directed and randomized operations on fpu_mul_acc, checked against a
// signed-arithmetic reference model (divide-toward-zero scaling, clamp).
module tb_fpu_mul_acc;
  import fpu_mul_acc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_mul_acc_if bus ();

  fpu_mul_acc #(.FRAC_BITS(32), .STEP_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic signed [127:0] SCALE = 128'sd4294967296;
  localparam logic signed [127:0] MAXV  = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINV  = -128'sh8000_0000_0000_0000;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] sext(input logic [63:0] v);
    return $signed({{64{v[63]}}, v});
  endfunction

  // Reference: exact product, scale by 2^32 truncating toward zero, clamp,
  // optionally add c and clamp again.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic mac,
                                output logic [63:0] r, output logic ovf);
    logic signed [127:0] q;
    q   = (sext(a) * sext(b)) / SCALE;
    ovf = 1'b0;
    if (q > MAXV) begin q = MAXV; ovf = 1'b1; end
    else if (q < MINV) begin q = MINV; ovf = 1'b1; end
    if (mac) begin
      q = q + sext(c);
      if (q > MAXV) begin q = MAXV; ovf = 1'b1; end
      else if (q < MINV) begin q = MINV; ovf = 1'b1; end
    end
    r = q[63:0];
  endfunction

  function automatic logic [63:0] rnd_val();
    logic signed [63:0] v;
    v = {$urandom, $urandom};
    v = v >>> $urandom_range(0, 40);
    if ($urandom_range(0, 15) == 0) v = '0;
    return v;
  endfunction

  // One complete operation: issue, time the result, check it, optionally
  // hold out_ready low for 'hold' cycles, then complete the handshake.
  task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic mac, input int hold);
    logic [63:0] er;
    logic        eo;
    int          lat;
    model(a, b, c, mac, er, eo);
    chk1({name, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    bus.in_mac   = mac;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = rnd_val();
    bus.in_b     = rnd_val();
    bus.in_c     = rnd_val();
    bus.in_mac   = ~mac;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_int({name, "_latency"}, lat, 33);
    chk64({name, "_data"}, bus.out_data, er);
    chk1({name, "_ovf"}, bus.out_ovf, eo);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in_a     = ONE;
        bus.in_b     = ONE;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk64({name, "_hold_data"}, bus.out_data, er);
      chk1({name, "_hold_ovf"}, bus.out_ovf, eo);
      chk1({name, "_hold_valid"}, bus.out_valid, 1'b1);
      chk1({name, "_hold_in_ready"}, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk1({name, "_post_valid"}, bus.out_valid, 1'b0);
    chk1({name, "_post_in_ready"}, bus.in_ready, 1'b1);
    $display("op %s a=%h b=%h c=%h mac=%b -> data=%h ovf=%b lat=%0d",
             name, a, b, c, mac, bus.out_data, bus.out_ovf, lat);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mac    = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_in_ready", bus.in_ready, 1'b1);
    chk64("reset_out_data", bus.out_data, 64'd0);
    chk1("reset_out_ovf", bus.out_ovf, 1'b0);

    do_op("mul_basic", 64'h0000_0001_8000_0000, 64'h0000_0002_0000_0000, 64'd0, 1'b0, 0);
    chk64("mul_basic_const", bus.out_data, 64'h0000_0003_0000_0000);
    do_op("sign_neg", 64'hFFFF_FFFE_8000_0000, 64'h0000_0002_0000_0000, 64'd0, 1'b0, 0);
    chk64("sign_neg_const", bus.out_data, 64'hFFFF_FFFD_0000_0000);
    do_op("sign_negneg", 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'd0, 1'b0, 0);
    chk64("sign_negneg_const", bus.out_data, 64'h0000_0001_0000_0000);
    do_op("mac", 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000,
          64'hFFFF_FFFF_0000_0000, 1'b1, 0);
    chk64("mac_const", bus.out_data, 64'h0000_0005_0000_0000);
    do_op("mac_off", 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000,
          64'hFFFF_FFFF_0000_0000, 1'b0, 0);
    chk64("mac_off_const", bus.out_data, 64'h0000_0006_0000_0000);
    do_op("sat_pos", 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'd0, 1'b0, 0);
    chk64("sat_pos_const", bus.out_data, SAT_MAX);
    chk1("sat_pos_ovf_const", bus.out_ovf, 1'b1);
    do_op("sat_neg", 64'h7FFF_FFFF_0000_0000, 64'hFFFF_FFFE_0000_0000, 64'd0, 1'b0, 0);
    chk64("sat_neg_const", bus.out_data, SAT_MIN);
    do_op("sat_mac", SAT_MAX - 64'd1, ONE, 64'h0000_0002_0000_0000, 1'b1, 0);
    chk64("sat_mac_const", bus.out_data, SAT_MAX);
    chk1("sat_mac_ovf_const", bus.out_ovf, 1'b1);
    do_op("min_exact", SAT_MIN, ONE, 64'd0, 1'b0, 0);
    do_op("zero_mac", 64'd0, 64'h0000_0005_0000_0000, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);
    do_op("backpressure", 64'h0000_0000_8000_0000, 64'hFFFF_FFF0_0000_0000, 64'd0, 1'b0, 10);

    // No spurious operation from the in_valid pulse seen while in DONE.
    repeat (40) @(posedge clk);
    #1;
    chk1("no_spurious_valid", bus.out_valid, 1'b0);
    chk1("no_spurious_ready", bus.in_ready, 1'b1);

    // Reset in the fifth BUSY cycle.
    bus.in_valid = 1'b1;
    bus.in_a     = 64'h0000_0003_0000_0000;
    bus.in_b     = 64'h0000_0003_0000_0000;
    bus.in_mac   = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk1("abort_out_valid", bus.out_valid, 1'b0);
    chk1("abort_in_ready", bus.in_ready, 1'b1);
    chk64("abort_out_data", bus.out_data, 64'd0);
    $display("reset mid-op applied");
    do_op("after_reset", ONE, ONE, 64'd0, 1'b0, 0);
    chk64("after_reset_const", bus.out_data, 64'h0000_0001_0000_0000);

    for (int n = 0; n < 20; n++) begin
      do_op($sformatf("rnd%0d", n), rnd_val(), rnd_val(), rnd_val(),
            1'($urandom_range(0, 1)), (n % 7 == 0) ? 4 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
